riscv_mem_arbiter: RTL and testbench

- Shares one single-port memory between the CPU's instruction-fetch port and its load/store data port.
- Arbitrates between the two, sequences each access over a req/ack handshake with the memory, and returns read data with a one-cycle ready pulse.
- Sits between riscv_cpu (with stall logic driven by the ready signals) and the unified instruction/data memory.

---
 rtl/riscv_mem_pkg.sv | 18 +
 rtl/riscv_mem_arbiter.sv | 127 ++++++++++++
 tb/tb_riscv_mem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared types and default constants for the instruction/data memory arbiter.
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam int unsigned DEF_MAX_DATA_STREAK = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 255;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates the CPU fetch and load/store ports onto one single-port memory
// with a req/ack handshake, a data-streak starvation guard and an ack timeout.
module riscv_mem_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned MAX_DATA_STREAK = DEF_MAX_DATA_STREAK,
  parameter int unsigned TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_ready,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err,
  output logic        busy
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam bit            TO_EN      = (TIMEOUT_CYCLES != 0);
  localparam logic [3:0]    STREAK_MAX = 4'(MAX_DATA_STREAK);

  state_t        state;
  owner_t        owner;
  logic [3:0]    data_streak;
  logic [TW-1:0] tcnt;
  logic          grant_d;
  logic          timed_out;

  assign grant_d   = d_req && (!if_req || (data_streak != STREAK_MAX));
  assign timed_out = TO_EN && (tcnt == TO_LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      owner       <= OWN_IF;
      data_streak <= '0;
      tcnt        <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      if_ready    <= 1'b0;
      if_rdata    <= '0;
      d_ready     <= 1'b0;
      d_rdata     <= '0;
      err         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (if_req || d_req) begin
            state   <= SERVE;
            mem_req <= 1'b1;
            tcnt    <= '0;
            if (grant_d) begin
              owner     <= OWN_D;
              mem_we    <= d_we;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
              // A contested data grant implies the streak is still below its cap.
              if (if_req) data_streak <= data_streak + 4'd1;
            end else begin
              owner       <= OWN_IF;
              mem_we      <= 1'b0;
              mem_addr    <= if_addr;
              mem_wdata   <= '0;
              data_streak <= '0;
            end
          end
        end

        SERVE: begin
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            err     <= 1'b0;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              d_rdata <= mem_we ? 32'd0 : mem_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= mem_rdata;
            end
          end else if (timed_out) begin
            state   <= RESP;
            mem_req <= 1'b0;
            err     <= 1'b1;
            if (owner == OWN_D) begin
              d_ready <= 1'b1;
              d_rdata <= '0;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= '0;
            end
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end

        RESP: begin
          // Ready/err are a single-cycle pulse; requests seen here are ignored.
          state    <= IDLE;
          if_ready <= 1'b0;
          d_ready  <= 1'b0;
          err      <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Scoreboard bench for riscv_mem_arbiter: bench-side memory responder,
// per-scenario tasks and an in-order completion monitor.
module tb_riscv_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req, d_req, d_we, mem_ack;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic        if_ready, d_ready, mem_req, mem_we, err, busy;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  riscv_mem_arbiter #(.MAX_DATA_STREAK(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err), .busy(busy)
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem_arr [logic [31:0]];
  int          ack_delay = 0;
  bit          no_ack = 1'b0;

  function automatic logic [31:0] rd(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return ~a;
  endfunction

  task automatic push_exp(input logic is_d, input logic [31:0] rdata, input logic e);
    exp_t x;
    x.is_d = is_d; x.rdata = rdata; x.err = e;
    sb.push_back(x);
  endtask

  // Memory responder: acks after ack_delay wait cycles, stores update the model.
  initial begin : responder
    int wc;
    wc = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_ack = 1'b0;
      if (reset || !mem_req) begin
        wc = 0;
      end else begin
        if (!no_ack && wc >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem_arr[mem_addr] = mem_wdata;
            mem_rdata = 32'hDEADBEEF;
          end else begin
            mem_rdata = rd(mem_addr);
          end
        end
        wc++;
      end
    end
  end

  // Completion monitor and requester-hold protocol check.
  bit if_pend = 1'b0;
  bit d_pend = 1'b0;
  always @(negedge clk) begin : monitor
    exp_t e;
    logic [31:0] act;
    if (if_ready && d_ready) begin
      errors++;
      $display("FAIL both_ready: if_ready=%0b d_ready=%0b, required not both", if_ready, d_ready);
    end
    if (if_ready || d_ready) begin
      checks++;
      act = d_ready ? d_rdata : if_rdata;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ready: d=%0b rdata=%h err=%0b, required no completion", d_ready, act, err);
      end else begin
        e = sb.pop_front();
        if (e.is_d !== d_ready || e.rdata !== act || e.err !== err) begin
          errors++;
          $display("FAIL completion: got d=%0b rdata=%h err=%0b, required d=%0b rdata=%h err=%0b",
                   d_ready, act, err, e.is_d, e.rdata, e.err);
        end
      end
    end
    if (reset) begin
      if_pend = 0; d_pend = 0;
    end else begin
      if (if_ready) if_pend = 0;
      else if (if_pend && !if_req) begin
        errors++;
        $display("FAIL proto_if_hold: if_req=0 before if_ready, required held");
      end
      if (d_ready) d_pend = 0;
      else if (d_pend && !d_req) begin
        errors++;
        $display("FAIL proto_d_hold: d_req=0 before d_ready, required held");
      end
      if (if_req && !if_ready) if_pend = 1;
      if (d_req && !d_ready) d_pend = 1;
    end
  end

  task automatic wait_done(input bit is_d, output int lat, output int mreq);
    bit done;
    done = 0; lat = 0; mreq = 0;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_req) mreq++;
      if (is_d ? d_ready : if_ready) begin
        done = 1;
        if (is_d) d_req = 0; else if_req = 0;
      end
    end
    if (!done) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_ready, d_ready, err, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 000000", {mem_req, mem_we, if_ready, d_ready, err, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_mem_bus: got %h, required 0", {mem_addr, mem_wdata});
    end
    checks++;
    if ({if_rdata, d_rdata} !== 64'd0) begin
      errors++;
      $display("FAIL reset_rdata: got %h, required 0", {if_rdata, d_rdata});
    end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single_fetch();
    int lat, mreq;
    mem_arr[32'h10] = 32'h00500093;
    push_exp(1'b0, 32'h00500093, 1'b0);
    if_addr = 32'h10; if_req = 1;
    wait_done(1'b0, lat, mreq);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL fetch_latency: got %0d, required 2", lat); end
    checks++;
    if (mreq !== 1) begin errors++; $display("FAIL fetch_mem_req_cycles: got %0d, required 1", mreq); end
    @(negedge clk);
  endtask

  task automatic test_both_same_cycle();
    int t, td, ti;
    bit seen;
    logic        st_we, f_we;
    logic [31:0] st_wd, f_wd;
    t = 0; td = -1; ti = -1; seen = 0;
    st_we = 0; st_wd = 0; f_we = 1; f_wd = 32'hFFFFFFFF;
    push_exp(1'b1, 32'd0, 1'b0);
    push_exp(1'b0, rd(32'h20), 1'b0);
    d_req = 1; d_we = 1; d_addr = 32'h100; d_wdata = 32'hCAFEBABE;
    if_req = 1; if_addr = 32'h20;
    while ((td < 0 || ti < 0) && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_req && !seen) begin seen = 1; st_we = mem_we; st_wd = mem_wdata; end
      if (mem_req && mem_addr == 32'h20) begin f_we = mem_we; f_wd = mem_wdata; end
      if (d_ready) begin td = t; d_req = 0; end
      if (if_ready) begin ti = t; if_req = 0; end
    end
    checks++;
    if (st_we !== 1'b1 || st_wd !== 32'hCAFEBABE) begin
      errors++;
      $display("FAIL store_bus: we=%0b wdata=%h, required we=1 wdata=cafebabe", st_we, st_wd);
    end
    checks++;
    if (f_we !== 1'b0 || f_wd !== 32'd0) begin
      errors++;
      $display("FAIL fetch_bus: we=%0b wdata=%h, required we=0 wdata=0", f_we, f_wd);
    end
    checks++;
    if (td !== 2 || ti !== 5) begin
      errors++;
      $display("FAIL both_order: d_ready@%0d if_ready@%0d, required 2 and 5", td, ti);
    end
    d_we = 0;
    @(negedge clk);
  endtask

  task automatic test_starvation();
    int t, nd, nd_at_if;
    t = 0; nd = 0; nd_at_if = -1;
    for (int k = 0; k < 4; k++) push_exp(1'b1, rd(32'h300 + 32'(4 * k)), 1'b0);
    push_exp(1'b0, rd(32'h40), 1'b0);
    push_exp(1'b1, rd(32'h310), 1'b0);
    if_req = 1; if_addr = 32'h40;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    while ((nd_at_if < 0 || nd < 5) && t < 100) begin
      @(negedge clk);
      t++;
      if (d_ready) begin
        nd++;
        if (nd == 5) d_req = 0; else d_addr = d_addr + 32'd4;
      end
      if (if_ready) begin nd_at_if = nd; if_req = 0; end
    end
    checks++;
    if (nd_at_if !== 4) begin errors++; $display("FAIL starve_guard: data done before fetch %0d, required 4", nd_at_if); end
    checks++;
    if (nd !== 5) begin errors++; $display("FAIL starve_after: data completions %0d, required 5", nd); end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_wait_states();
    int lat, mreq, unstable;
    bit done, seen;
    logic        w0;
    logic [31:0] a0;
    lat = 0; mreq = 0; unstable = 0; done = 0; seen = 0; w0 = 0; a0 = 0;
    mem_arr[32'h200] = 32'h12345678;
    ack_delay = 4;
    push_exp(1'b1, 32'h12345678, 1'b0);
    d_req = 1; d_we = 0; d_addr = 32'h200;
    while (!done && lat < 60) begin
      @(negedge clk);
      lat++;
      if (mem_req) begin
        mreq++;
        if (!seen) begin seen = 1; a0 = mem_addr; w0 = mem_we; end
        else if (mem_addr !== a0 || mem_we !== w0) unstable++;
      end
      if (d_ready) begin done = 1; d_req = 0; end
    end
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL wait_latency: got %0d, required 6", lat); end
    checks++;
    if (mreq !== 5 || unstable !== 0 || a0 !== 32'h200) begin
      errors++;
      $display("FAIL wait_bus_stable: req_cycles=%0d unstable=%0d addr=%h, required 5 0 00000200", mreq, unstable, a0);
    end
    ack_delay = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat, mreq;
    no_ack = 1;
    push_exp(1'b1, 32'd0, 1'b1);
    d_req = 1; d_we = 0; d_addr = 32'h400;
    wait_done(1'b1, lat, mreq);
    checks++;
    if (lat !== 9 || mreq !== 8) begin
      errors++;
      $display("FAIL timeout_timing: ready@%0d req_cycles=%0d, required 9 and 8", lat, mreq);
    end
    no_ack = 0;
    @(negedge clk);
    push_exp(1'b0, rd(32'h44), 1'b0);
    if_req = 1; if_addr = 32'h44;
    wait_done(1'b0, lat, mreq);
    checks++;
    if (lat !== 2 || mreq !== 1) begin
      errors++;
      $display("FAIL after_timeout: ready@%0d req_cycles=%0d, required 2 and 1", lat, mreq);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_serve();
    int t, nd, td, ti;
    t = 0; nd = 0;
    ack_delay = 2;
    for (int k = 0; k < 3; k++) push_exp(1'b1, rd(32'h500 + 32'(4 * k)), 1'b0);
    if_req = 1; if_addr = 32'h60;
    d_req = 1; d_we = 0; d_addr = 32'h500;
    while (!(nd == 3 && mem_req && mem_addr == 32'h50C) && t < 100) begin
      @(negedge clk);
      t++;
      if (d_ready) begin nd++; d_addr = d_addr + 32'd4; end
    end
    #2 reset = 1;
    #1;
    checks++;
    if ({mem_req, busy, if_ready, d_ready, err} !== 5'b0 || nd !== 3) begin
      errors++;
      $display("FAIL async_reset: req/busy/rdy/rdy/err=%b done=%0d, required 00000 and 3",
               {mem_req, busy, if_ready, d_ready, err}, nd);
    end
    if_req = 0; d_req = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    ack_delay = 0;
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL pre_reset_pending: got %0d, required 0", sb.size()); end
    @(negedge clk);
    push_exp(1'b1, rd(32'h700), 1'b0);
    push_exp(1'b0, rd(32'h64), 1'b0);
    d_req = 1; d_addr = 32'h700; if_req = 1; if_addr = 32'h64;
    t = 0; td = -1; ti = -1;
    while ((td < 0 || ti < 0) && t < 60) begin
      @(negedge clk);
      t++;
      if (d_ready) begin td = t; d_req = 0; end
      if (if_ready) begin ti = t; if_req = 0; end
    end
    checks++;
    if (td !== 2 || ti !== 5) begin
      errors++;
      $display("FAIL streak_cleared: d_ready@%0d if_ready@%0d, required 2 and 5", td, ti);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    test_reset();
    test_single_fetch();
    test_both_same_cycle();
    test_starvation();
    test_wait_states();
    test_timeout();
    test_reset_mid_serve();
    checks++;
    if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_drain: %0d left, required 0", sb.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
